// File: rtl/seq_detect_pkg.sv
// Shared constants, types and helpers for the programmable sequence detector.
package seq_detect_pkg;

    // Width needed to hold a pattern length from 0 up to max_len inclusive.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Power-on pattern is the legacy fixed 1011 detector.
    localparam logic [7:0]  PAT_RST_DEF = 8'b0000_1011;
    localparam int unsigned LEN_RST_DEF = 4;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with sticky overflow flag; clear has priority.
module seq_match_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    // Count matches, holding at all-ones and flagging further matches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_inc) begin
            if (&r_count) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: runtime pattern/length, selectable
// overlap, one-cycle match pulse and saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          CNT_W   = 16,
    parameter logic [MAX_LEN-1:0]   PAT_RST = MAX_LEN'(PAT_RST_DEF),
    parameter int unsigned          LEN_RST = LEN_RST_DEF,
    localparam int unsigned         LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inp_bit,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_ovf
);

    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LenRstW = LEN_W'(LEN_RST);
    localparam logic [LEN_W:0]   OneExt  = (LEN_W + 1)'(1);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    ovl_mode_e          r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_seen;

    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_fill_inc;
    logic               w_accept;
    logic               w_fill_ok;
    logic               w_len_ok;
    logic               w_match;

    // A bit presented alongside cfg_load is dropped; the new config starts clean.
    assign w_accept    = in_valid && !cfg_load;
    assign w_hist_nxt  = {r_hist[MAX_LEN-2:0], inp_bit};
    assign w_len_clamp = (pat_len > MaxLenW) ? MaxLenW : pat_len;
    assign w_fill_inc  = (r_fill == MaxLenW) ? r_fill : r_fill + LEN_W'(1);
    assign w_fill_ok   = ({1'b0, r_fill} + OneExt) >= {1'b0, r_len};
    assign w_len_ok    = r_len >= LEN_W'(2);

    // Mask selecting the low r_len bits of history and pattern.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            w_mask[i] = LEN_W'(i) < r_len;
        end
    end

    assign w_match = w_accept && w_len_ok && w_fill_ok
                     && ((w_hist_nxt & w_mask) == (r_pat & w_mask));

    // Active configuration registers, loaded on the cfg_load strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pat <= PAT_RST;
            r_len <= LenRstW;
            r_ovl <= OVL_ON;
        end else if (cfg_load) begin
            r_pat <= pattern;
            r_len <= w_len_clamp;
            r_ovl <= overlap_en ? OVL_ON : OVL_OFF;
        end
    end

    // History shift register and fill count; fill restarts after a
    // non-overlapping match so matched bits are never reused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_hist <= w_hist_nxt;
            r_fill <= (w_match && r_ovl == OVL_OFF) ? '0 : w_fill_inc;
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seen <= 1'b0;
        end else begin
            r_seen <= w_match;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_inc   (w_match),
        .i_clr   (count_clr),
        .o_count (match_count),
        .o_ovf   (cnt_ovf)
    );

    assign seq_seen = r_seen;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a queue-based reference model predicts
// outputs per cycle; a monitor pops and compares after each rising edge.
module tb_seq_detect_prog;

    logic        clk;
    logic        reset_n;
    logic        inp_bit;
    logic        in_valid;
    logic        cfg_load;
    logic [7:0]  pattern;
    logic [3:0]  pat_len;
    logic        overlap_en;
    logic        count_clr;
    logic        seq_seen;
    logic [15:0] match_count;
    logic        cnt_ovf;
    logic        seq_seen2;
    logic [1:0]  match_count2;
    logic        cnt_ovf2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit seen;
        int c16;
        bit o16;
        int c2;
        bit o2;
    } exp_t;

    exp_t q[$];

    // Reference model state
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       bits[$];
    int       m_c16, m_c2;
    bit       m_o16, m_o2;

    seq_detect_prog dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .inp_bit     (inp_bit),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .count_clr   (count_clr),
        .seq_seen    (seq_seen),
        .match_count (match_count),
        .cnt_ovf     (cnt_ovf)
    );

    seq_detect_prog #(
        .CNT_W (2)
    ) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .inp_bit     (inp_bit),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .count_clr   (count_clr),
        .seq_seen    (seq_seen2),
        .match_count (match_count2),
        .cnt_ovf     (cnt_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'b0000_1011;
        m_len = 4;
        m_ovl = 1'b1;
        bits.delete();
        m_c16 = 0;
        m_o16 = 1'b0;
        m_c2  = 0;
        m_o2  = 1'b0;
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the prediction.
    task automatic step(input bit b, input bit v, input bit load, input bit clr);
        exp_t e;
        bit   match;
        @(negedge clk);
        inp_bit   = b;
        in_valid  = v;
        cfg_load  = load;
        count_clr = clr;
        match = 1'b0;
        if (load) begin
            m_pat = pattern;
            m_len = (int'(pat_len) > 8) ? 8 : int'(pat_len);
            m_ovl = overlap_en;
            bits.delete();
        end else if (v) begin
            bits.push_back(b);
            if (bits.size() > 8) void'(bits.pop_front());
            if (m_len >= 2 && bits.size() >= m_len) begin
                match = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (bits[bits.size() - 1 - i] != m_pat[i]) match = 1'b0;
                end
            end
            if (match && !m_ovl) bits.delete();
        end
        if (clr) begin
            m_c16 = 0; m_o16 = 1'b0;
            m_c2  = 0; m_o2  = 1'b0;
        end else if (match) begin
            if (m_c16 == 65535) m_o16 = 1'b1; else m_c16++;
            if (m_c2 == 3)      m_o2  = 1'b1; else m_c2++;
        end
        e.seen = match;
        e.c16  = m_c16;
        e.o16  = m_o16;
        e.c2   = m_c2;
        e.o2   = m_o2;
        q.push_back(e);
    endtask

    task automatic bit_in(input bit b);
        step(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input bit [7:0] p, input int len, input bit ovl);
        pattern    = p;
        pat_len    = 4'(len);
        overlap_en = ovl;
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Feed the low n bits of p, most significant first.
    task automatic feed(input bit [7:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(p[i]);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("async_rst_seen", int'(seq_seen), 0);
        chk("async_rst_count", int'(match_count), 0);
        chk("async_rst_ovf", int'(cnt_ovf), 0);
        chk("async_rst_count2", int'(match_count2), 0);
        chk("async_rst_ovf2", int'(cnt_ovf2), 0);
        model_reset();
        @(negedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    // Monitor: compare predicted outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seq_seen", int'(seq_seen), int'(e.seen));
                chk("match_count", int'(match_count), e.c16);
                chk("cnt_ovf", int'(cnt_ovf), int'(e.o16));
                chk("seq_seen_w2", int'(seq_seen2), int'(e.seen));
                chk("match_count_w2", int'(match_count2), e.c2);
                chk("cnt_ovf_w2", int'(cnt_ovf2), int'(e.o2));
            end
        end
    end

    initial begin
        reset_n    = 1'b1;
        inp_bit    = 1'b0;
        in_valid   = 1'b0;
        cfg_load   = 1'b0;
        pattern    = 8'h00;
        pat_len    = 4'd0;
        overlap_en = 1'b0;
        count_clr  = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("reset_seen", int'(seq_seen), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_ovf", int'(cnt_ovf), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset-default pattern 1011
        feed(8'b1011, 4);
        idle(2);

        // Overlapping and non-overlapping 101
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(8'b101, 3, 1'b1);
        feed(8'b10101, 5);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(8'b101, 3, 1'b0);
        feed(8'b10101, 5);
        idle(1);

        // Gapped input with suffix recovery on 1011
        cfg(8'b1011, 4, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            bit [4:0] s;
            s = 5'b11011;
            bit_in(s[i]);
            if (i != 0) idle(2);
        end
        idle(1);

        // cfg_load mid-stream discards history and the coincident bit
        feed(8'b101, 3);
        pattern    = 8'b1011;
        pat_len    = 4'd4;
        overlap_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        feed(8'b011, 3);
        bit_in(1'b1);
        feed(8'b1011, 4);
        idle(1);

        // Length corners: zero length never matches; oversize clamps to 8
        cfg(8'h00, 0, 1'b1);
        for (int i = 0; i < 10; i++) bit_in(1'b0);
        cfg(8'hA5, 12, 1'b1);
        feed(8'hA5, 8);
        idle(1);

        // Counter saturation on the narrow instance, then clear vs match
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg(8'b101, 3, 1'b1);
        feed(8'b1010_1010, 8);
        bit_in(1'b1);
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);

        // Asynchronous reset mid-pattern, then defaults again
        feed(8'b101, 3);
        async_reset();
        feed(8'b1011, 4);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12))
                                                   : int'($urandom_range(2, 4));
                cfg(8'($urandom), len, 1'($urandom));
            end else begin
                step(1'($urandom), $urandom_range(0, 9) < 7, 1'b0,
                     $urandom_range(0, 39) == 0);
            end
        end

        // Drain the scoreboard within a bounded number of cycles
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
